// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: the signal bundle around the instruction-memory arbiter.
//   fetch side  : f_req/f_addr in, f_gnt/f_valid/f_rdata/f_misalign out
//   loader side : l_req/l_we/l_addr/l_wdata in, l_gnt/l_ack/l_rdata/l_err out
//   mode        : boot_req in, cpu_hold out
//   memory side : m_en/m_we/m_addr/m_wdata out, m_rdata in (1-cycle latency)
// slave  = arbiter view, master = view of whatever surrounds the arbiter.
interface imem_arbiter_if #(
    parameter int MEM_AW = 15
) ();
    logic              f_req;
    logic [31:0]       f_addr;
    logic              f_gnt;
    logic              f_valid;
    logic [31:0]       f_rdata;
    logic              f_misalign;

    logic              l_req;
    logic              l_we;
    logic [31:0]       l_addr;
    logic [31:0]       l_wdata;
    logic              l_gnt;
    logic              l_ack;
    logic [31:0]       l_rdata;
    logic              l_err;

    logic              boot_req;
    logic              cpu_hold;

    logic              m_en;
    logic              m_we;
    logic [MEM_AW-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;

    modport slave (
        input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, boot_req, m_rdata,
        output f_gnt, f_valid, f_rdata, f_misalign,
        output l_gnt, l_ack, l_rdata, l_err,
        output cpu_hold, m_en, m_we, m_addr, m_wdata
    );

    modport master (
        output f_req, f_addr, l_req, l_we, l_addr, l_wdata, boot_req, m_rdata,
        input  f_gnt, f_valid, f_rdata, f_misalign,
        input  l_gnt, l_ack, l_rdata, l_err,
        input  cpu_hold, m_en, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares a single-port word-organised instruction memory between
// the CPU fetch port and the loader port, with fetch anti-starvation and a
// boot mode that holds the CPU while the loader rewrites program memory.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : imem_arbiter_if.slave (fetch, loader, mode and memory signals)
//
// state       | meaning
// ------------+---------------------------------------------------------
// MODE_RUN    | normal operation, fetch and loader arbitrated per cycle
// MODE_DRAIN  | one cycle with no fetch grant so an in-flight fetch returns
// MODE_BOOT   | cpu_hold=1, loader only; leaves when boot_req drops
module imem_arbiter #(
    parameter int MEM_AW       = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           reset,
    imem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_DRAIN = 2'd1,
        MODE_BOOT  = 2'd2
    } mode_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    mode_e      mode_q, mode_d;
    logic [3:0] starve_q, starve_d;
    logic       f_pend_q, f_pend_d;
    logic       f_mis_q, f_mis_d;
    logic       l_pend_q, l_pend_d;
    logic       l_err_q, l_err_d;
    logic       l_rd_q, l_rd_d;

    logic       run;
    logic       l_mis;
    logic       f_gnt;
    logic       l_gnt;

    // upper address bits wrap away by design
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.f_addr[31:MEM_AW+2], bus.l_addr[31:MEM_AW+2]};

    always_comb begin
        mode_d   = mode_q;
        starve_d = starve_q;
        run      = (mode_q == MODE_RUN);
        l_mis    = (bus.l_addr[1:0] != 2'b00);

        case (mode_q)
            MODE_RUN:   if (bus.boot_req) mode_d = MODE_DRAIN;
            MODE_DRAIN: mode_d = MODE_BOOT;
            MODE_BOOT:  if (!bus.boot_req) mode_d = MODE_RUN;
            default:    mode_d = MODE_RUN;
        endcase

        // loader wins contested cycles until fetch has lost LIMIT in a row
        f_gnt = run && bus.f_req && (!bus.l_req || (starve_q == LIMIT));
        l_gnt = bus.l_req && !f_gnt;

        if (!run || !bus.f_req || f_gnt) begin
            starve_d = 4'd0;
        end else if (l_gnt && (starve_q != LIMIT)) begin
            starve_d = starve_q + 4'd1;
        end

        f_pend_d = f_gnt;
        f_mis_d  = f_gnt && (bus.f_addr[1:0] != 2'b00);
        l_pend_d = l_gnt;
        l_err_d  = l_gnt && l_mis;
        l_rd_d   = l_gnt && !bus.l_we && !l_mis;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q   <= MODE_RUN;
            starve_q <= 4'd0;
            f_pend_q <= 1'b0;
            f_mis_q  <= 1'b0;
            l_pend_q <= 1'b0;
            l_err_q  <= 1'b0;
            l_rd_q   <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            starve_q <= starve_d;
            f_pend_q <= f_pend_d;
            f_mis_q  <= f_mis_d;
            l_pend_q <= l_pend_d;
            l_err_q  <= l_err_d;
            l_rd_q   <= l_rd_d;
        end
    end

    assign bus.f_gnt      = f_gnt;
    assign bus.l_gnt      = l_gnt;
    assign bus.m_en       = f_gnt || (l_gnt && !l_mis);
    assign bus.m_we       = l_gnt && bus.l_we && !l_mis;
    assign bus.m_addr     = f_gnt ? bus.f_addr[MEM_AW+1:2] : bus.l_addr[MEM_AW+1:2];
    assign bus.m_wdata    = bus.l_wdata;

    assign bus.f_valid    = f_pend_q;
    assign bus.f_misalign = f_mis_q;
    assign bus.f_rdata    = f_pend_q ? bus.m_rdata : 32'd0;
    assign bus.l_ack      = l_pend_q;
    assign bus.l_err      = l_err_q;
    // write acks and error acks return zero data
    assign bus.l_rdata    = l_rd_q ? bus.m_rdata : 32'd0;
    assign bus.cpu_hold   = (mode_q == MODE_BOOT);
endmodule
